// File: rtl/draw_pkg.sv
// Shared types for the drawing engine line walkers.
package draw_pkg;

  localparam int CORDW_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_0,
    ST_INIT_1,
    ST_DRAW,
    ST_DONE
  } line_state_t;

  // Widths follow CORDW: coordinate, |delta| (one extra bit),
  // error term (two extra bits), doubled error (three extra bits).
  typedef logic signed [CORDW_DEF-1:0] coord_t;
  typedef logic signed [CORDW_DEF:0]   delta_t;
  typedef logic signed [CORDW_DEF+1:0] err_t;
  typedef logic signed [CORDW_DEF+2:0] err2_t;

endpackage

// File: rtl/draw_line_clip_if.sv
// Command / pixel stream bundle between the draw-command decoder,
// the line walker and the framebuffer write arbiter.
interface draw_line_clip_if #(parameter int CORDW = draw_pkg::CORDW_DEF);

  logic                    start_i;
  logic                    abort_i;
  logic signed [CORDW-1:0] x0_i;
  logic signed [CORDW-1:0] y0_i;
  logic signed [CORDW-1:0] x1_i;
  logic signed [CORDW-1:0] y1_i;
  logic signed [CORDW-1:0] clip_xmin_i;
  logic signed [CORDW-1:0] clip_ymin_i;
  logic signed [CORDW-1:0] clip_xmax_i;
  logic signed [CORDW-1:0] clip_ymax_i;
  logic                    pix_ready_i;
  logic signed [CORDW-1:0] x_o;
  logic signed [CORDW-1:0] y_o;
  logic                    pix_valid_o;
  logic                    pix_last_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output start_i, abort_i, x0_i, y0_i, x1_i, y1_i,
           clip_xmin_i, clip_ymin_i, clip_xmax_i, clip_ymax_i, pix_ready_i,
    input  x_o, y_o, pix_valid_o, pix_last_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, x0_i, y0_i, x1_i, y1_i,
           clip_xmin_i, clip_ymin_i, clip_xmax_i, clip_ymax_i, pix_ready_i,
    output x_o, y_o, pix_valid_o, pix_last_o, busy_o, done_o
  );

endinterface

// File: rtl/line_step.sv
// One Bresenham step: given the current point and error term, produce
// the next point and error. Purely combinational so other walkers
// (e.g. the triangle filler) can reuse it.
module line_step #(
  parameter int CORDW = draw_pkg::CORDW_DEF
) (
  input  logic signed [CORDW+1:0] err_i,
  input  logic signed [CORDW:0]   dx_i,
  input  logic signed [CORDW:0]   dy_i,
  input  logic                    sx_neg_i,  // 1: x steps by -1
  input  logic                    sy_neg_i,  // 1: y steps by -1
  input  logic signed [CORDW-1:0] x_i,
  input  logic signed [CORDW-1:0] y_i,
  output logic signed [CORDW-1:0] x_o,
  output logic signed [CORDW-1:0] y_o,
  output logic signed [CORDW+1:0] err_o
);

  logic signed [CORDW+2:0] e2;
  logic signed [CORDW+2:0] dx_w;
  logic signed [CORDW+2:0] dy_w;
  logic signed [CORDW+1:0] dx_e;
  logic signed [CORDW+1:0] dy_e;
  logic                    movx;
  logic                    movy;

  // Decide which axes move and apply the step and error update.
  always_comb begin
    e2   = {err_i, 1'b0};
    dx_w = {{2{dx_i[CORDW]}}, dx_i};
    dy_w = {{2{dy_i[CORDW]}}, dy_i};
    dx_e = {dx_i[CORDW], dx_i};
    dy_e = {dy_i[CORDW], dy_i};
    movx = (e2 >= dy_w);
    movy = (e2 <= dx_w);

    x_o   = x_i;
    y_o   = y_i;
    err_o = err_i;
    if (movx) begin
      x_o   = sx_neg_i ? (x_i - CORDW'(1)) : (x_i + CORDW'(1));
      err_o = err_o + dy_e;
    end
    if (movy) begin
      y_o   = sy_neg_i ? (y_i - CORDW'(1)) : (y_i + CORDW'(1));
      err_o = err_o + dx_e;
    end
  end

endmodule

// File: rtl/draw_line_clip.sv
// Bresenham line walker with inclusive clip window and valid/ready
// pixel output. One pixel retires per cycle; clipped pixels retire
// without a handshake.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start_i; endpoints and window latched on start
// INIT_0  | compute |dx|, -|dy| and step directions
// INIT_1  | seed error term, load first pixel
// DRAW    | present / retire one pixel per cycle
// DONE    | one-cycle done_o pulse, busy_o low
module draw_line_clip
  import draw_pkg::*;
#(
  parameter int CORDW = CORDW_DEF
) (
  input  logic              clk,
  input  logic              reset_i,
  draw_line_clip_if.slave   bus
);

  line_state_t state_q, state_d;

  logic signed [CORDW-1:0] x0_q, x0_d, y0_q, y0_d;
  logic signed [CORDW-1:0] x1_q, x1_d, y1_q, y1_d;
  logic signed [CORDW-1:0] xmin_q, xmin_d, ymin_q, ymin_d;
  logic signed [CORDW-1:0] xmax_q, xmax_d, ymax_q, ymax_d;
  logic signed [CORDW:0]   dx_q, dx_d, dy_q, dy_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [CORDW+1:0] err_q, err_d;
  logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;

  logic signed [CORDW:0]   diff_x;
  logic signed [CORDW:0]   diff_y;
  logic signed [CORDW-1:0] step_x;
  logic signed [CORDW-1:0] step_y;
  logic signed [CORDW+1:0] step_err;
  logic                    in_win;
  logic                    at_end;
  logic                    drawing;
  logic                    pix_valid;
  logic                    retire;

  line_step #(.CORDW(CORDW)) u_step (
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .x_o      (step_x),
    .y_o      (step_y),
    .err_o    (step_err)
  );

  // Clip compare, endpoint detect and retire condition for the current pixel.
  always_comb begin
    diff_x    = {x1_q[CORDW-1], x1_q} - {x0_q[CORDW-1], x0_q};
    diff_y    = {y1_q[CORDW-1], y1_q} - {y0_q[CORDW-1], y0_q};
    in_win    = (x_q >= xmin_q) && (x_q <= xmax_q) &&
                (y_q >= ymin_q) && (y_q <= ymax_q);
    at_end    = (x_q == x1_q) && (y_q == y1_q);
    drawing   = (state_q == ST_DRAW);
    pix_valid = drawing && in_win;
    // Out-of-window pixels never wait on the consumer.
    retire    = pix_valid ? bus.pix_ready_i : drawing;
  end

  // Next-state and datapath update for the line FSM.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    xmin_d   = xmin_q;
    ymin_d   = ymin_q;
    xmax_d   = xmax_q;
    ymax_d   = ymax_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;
    x_d      = x_q;
    y_d      = y_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          x0_d    = bus.x0_i;
          y0_d    = bus.y0_i;
          x1_d    = bus.x1_i;
          y1_d    = bus.y1_i;
          xmin_d  = bus.clip_xmin_i;
          ymin_d  = bus.clip_ymin_i;
          xmax_d  = bus.clip_xmax_i;
          ymax_d  = bus.clip_ymax_i;
          state_d = ST_INIT_0;
        end
      end
      ST_INIT_0: begin
        dx_d     = diff_x[CORDW] ? -diff_x : diff_x;
        dy_d     = diff_y[CORDW] ? diff_y : -diff_y;
        sx_neg_d = !(x0_q < x1_q);
        sy_neg_d = !(y0_q < y1_q);
        state_d  = bus.abort_i ? ST_DONE : ST_INIT_1;
      end
      ST_INIT_1: begin
        err_d   = {dx_q[CORDW], dx_q} + {dy_q[CORDW], dy_q};
        x_d     = x0_q;
        y_d     = y0_q;
        state_d = bus.abort_i ? ST_DONE : ST_DRAW;
      end
      ST_DRAW: begin
        if (retire) begin
          if (at_end) begin
            state_d = ST_DONE;
          end else begin
            x_d   = step_x;
            y_d   = step_y;
            err_d = step_err;
          end
        end
        if (bus.abort_i) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      xmin_q   <= '0;
      ymin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      xmin_q   <= xmin_d;
      ymin_q   <= ymin_d;
      xmax_q   <= xmax_d;
      ymax_q   <= ymax_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign bus.x_o         = x_q;
  assign bus.y_o         = y_q;
  assign bus.pix_valid_o = pix_valid;
  assign bus.pix_last_o  = pix_valid && at_end;
  assign bus.busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done_o      = (state_q == ST_DONE);

endmodule
